// File: rtl/dmx8_32bits_buf.sv
// Buffered 1-to-8 demultiplexer. One producer word is steered by {s2,s1,s0}
// into one of eight single-word holding slots, and each slot has its own
// valid/ready handshake, so a stalled consumer blocks only its own channel.
module dmx8_32bits_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     d,
  input  logic                 s2,
  input  logic                 s1,
  input  logic                 s0,
  input  logic                 d_valid,
  output logic                 d_ready,
  output logic [8*WIDTH-1:0]   y,
  output logic [7:0]           y_valid,
  input  logic [7:0]           y_ready,
  output logic [3:0]           occ
);

  logic [2:0]       sel;
  logic             accept;
  logic [7:0]       load;
  logic [7:0]       drain;
  logic [7:0]       valid_d;
  logic [7:0]       valid_q;
  logic [3:0]       occ_d;
  logic [3:0]       occ_q;
  logic [WIDTH-1:0] data_q [8];

  assign sel = {s2, s1, s0};

  // Accept/drain decode and next-state valid vector; occupancy tracks popcount.
  always_comb begin
    d_ready = ~valid_q[sel] | y_ready[sel];
    accept  = d_valid & d_ready;
    load    = '0;
    if (accept) begin
      load[sel] = 1'b1;
    end
    drain   = valid_q & y_ready;
    // A load into a draining slot wins: the slot stays full with the new word.
    valid_d = (valid_q & ~drain) | load;
    occ_d   = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      occ_d = occ_d + {3'b000, valid_d[k]};
    end
  end

  // Slot data: loaded on accept, otherwise held (drain does not clear data).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < 8; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 8; k++) begin
        if (load[k]) begin
          data_q[k] <= d;
        end
      end
    end
  end

  // Slot valid flags and registered occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Flatten slot data onto the channel bus.
  always_comb begin
    y = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      y[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  assign y_valid = valid_q;
  assign occ     = occ_q;

endmodule

// File: tb/tb_dmx8_32bits_buf.sv
// Scoreboard bench for dmx8_32bits_buf: accepted words are queued per
// channel and a negedge monitor checks each word as its consumer drains it.
module tb_dmx8_32bits_buf;

  logic         clk;
  logic         reset_n;
  logic [31:0]  d;
  logic         s2, s1, s0;
  logic         d_valid;
  logic         d_ready;
  logic [255:0] y;
  logic [7:0]   y_valid;
  logic [7:0]   y_ready;
  logic [3:0]   occ;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [8][$];

  dmx8_32bits_buf #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (d),
    .s2      (s2),
    .s1      (s1),
    .s0      (s0),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .y       (y),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .occ     (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] chan(input int k);
    return y[k*32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one word on channel ch for one edge; expects d_ready == exp_acc.
  task automatic write_word(input int ch, input logic [31:0] val, input bit exp_acc);
    {s2, s1, s0} = 3'(ch);
    d       = val;
    d_valid = 1'b1;
    #1;
    chk($sformatf("d_ready ch%0d", ch), {63'b0, d_ready}, {63'b0, exp_acc});
    if (exp_acc) exp_q[ch].push_back(val);
    @(posedge clk); #1;
    d_valid = 1'b0;
  endtask

  task automatic drain(input logic [7:0] mask);
    y_ready = mask;
    @(posedge clk); #1;
    y_ready = '0;
  endtask

  // Monitor: every slot about to drain must present the oldest queued word.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < 8; k++) begin
        if (y_valid[k] && y_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL drain ch%0d: got %0h expected no word", k, chan(k));
          end else begin
            chk($sformatf("drain ch%0d", k), {32'b0, chan(k)}, {32'b0, exp_q[k].pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    d = '0; {s2, s1, s0} = 3'd0; d_valid = 1'b0; y_ready = '0;
    #2;
    chk("reset y_valid", {56'b0, y_valid}, 64'h0);
    chk("reset occ", {60'b0, occ}, 64'h0);
    chk("reset d_ready", {63'b0, d_ready}, 64'h1);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic route to ch5.
    write_word(5, 32'hDEADBEEF, 1'b1);
    chk("route y_valid", {56'b0, y_valid}, 64'h20);
    chk("route ch5", {32'b0, chan(5)}, 64'hDEADBEEF);
    chk("route occ", {60'b0, occ}, 64'h1);
    drain(8'h20);
    chk("route drained occ", {60'b0, occ}, 64'h0);

    // Fill all slots, then a blocked write to ch2.
    for (int k = 0; k < 8; k++) write_word(k, 32'h0000_0010 + 32'(k), 1'b1);
    chk("fill occ", {60'b0, occ}, 64'h8);
    chk("fill y_valid", {56'b0, y_valid}, 64'hFF);
    write_word(2, 32'h0000_0099, 1'b0);
    chk("fill ch2 held", {32'b0, chan(2)}, 64'h12);
    chk("fill occ held", {60'b0, occ}, 64'h8);
    drain(8'hFF);
    chk("fill drained occ", {60'b0, occ}, 64'h0);

    // Pass-through: drain and reload ch4 on the same edge.
    write_word(4, 32'h1111_1111, 1'b1);
    y_ready = 8'h10;
    write_word(4, 32'h2222_2222, 1'b1);
    y_ready = '0;
    chk("pass y_valid", {56'b0, y_valid}, 64'h10);
    chk("pass ch4", {32'b0, chan(4)}, 64'h2222_2222);
    chk("pass occ", {60'b0, occ}, 64'h1);
    drain(8'h10);

    // Independent stall: ch1 held full does not block ch6.
    write_word(1, 32'h0BAD_0001, 1'b1);
    write_word(6, 32'hA5A5_A5A5, 1'b1);
    chk("indep y_valid", {56'b0, y_valid}, 64'h42);
    chk("indep occ", {60'b0, occ}, 64'h2);
    drain(8'h42);

    // Multi-drain of slots 0, 3, 7 in one edge.
    write_word(0, 32'hC0C0_0000, 1'b1);
    write_word(3, 32'hC3C3_0003, 1'b1);
    write_word(7, 32'hC7C7_0007, 1'b1);
    chk("multi occ before", {60'b0, occ}, 64'h3);
    drain(8'h89);
    chk("multi y_valid", {56'b0, y_valid}, 64'h0);
    chk("multi occ", {60'b0, occ}, 64'h0);
    chk("multi ch0 data", {32'b0, chan(0)}, 64'hC0C0_0000);
    chk("multi ch3 data", {32'b0, chan(3)}, 64'hC3C3_0003);
    chk("multi ch7 data", {32'b0, chan(7)}, 64'hC7C7_0007);

    // Select change while stalled.
    write_word(0, 32'h5555_0000, 1'b1);
    {s2, s1, s0} = 3'd0; d = 32'h7777_0001; d_valid = 1'b1;
    #1;
    chk("stall sel0 d_ready", {63'b0, d_ready}, 64'h0);
    {s2, s1, s0} = 3'd1;
    #1;
    chk("stall sel1 d_ready", {63'b0, d_ready}, 64'h1);
    exp_q[1].push_back(32'h7777_0001);
    @(posedge clk); #1;
    d_valid = 1'b0;
    chk("stall y_valid", {56'b0, y_valid}, 64'h03);
    drain(8'h03);

    // Asynchronous reset mid-cycle with slot 3 full.
    write_word(3, 32'h3333_3333, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async y_valid", {56'b0, y_valid}, 64'h0);
    chk("async occ", {60'b0, occ}, 64'h0);
    chk("async y zero", {63'b0, (y == '0)}, 64'h1);
    exp_q[3].delete();
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post reset occ", {60'b0, occ}, 64'h0);
    write_word(2, 32'hABCD_0002, 1'b1);
    chk("post reset y_valid", {56'b0, y_valid}, 64'h04);
    drain(8'h04);

    for (int k = 0; k < 8; k++)
      chk($sformatf("queue empty ch%0d", k), 64'(exp_q[k].size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
